// File: rtl/next_state_sequencer_if.sv
// Sequencer bus: control-word sequencing fields in, microstore address and status out.
interface next_state_sequencer_if #(
    parameter int unsigned AW = 6
);
    logic [2:0]    N;
    logic          inv;
    logic [1:0]    select;
    logic [AW-1:0] cr;
    logic [3:0]    cond_in;
    logic [AW-1:0] enc_state;
    logic [AW-1:0] state;
    logic          hold;
    logic          wd_fault;

    modport master (
        output N, inv, select, cr, cond_in, enc_state,
        input  state, hold, wd_fault
    );

    modport slave (
        input  N, inv, select, cr, cond_in, enc_state,
        output state, hold, wd_fault
    );
endinterface

// File: rtl/next_state_sequencer.sv
// Microprogram sequencer: registers the next microstore address from the control word.
// Optional hold watchdog enabled by defining NEXT_STATE_SEQUENCER_WATCHDOG_EN.
module next_state_sequencer #(
    parameter int unsigned   AW          = 6,
    parameter logic [AW-1:0] RESET_STATE = AW'(0),
    parameter logic [AW-1:0] FAULT_STATE = AW'(63),
    parameter logic [7:0]    WD_LIMIT    = 8'd255
) (
    input logic                   clk,
    input logic                   reset_n,
    next_state_sequencer_if.slave bus
);

    localparam logic [2:0] N_DECODE  = 3'b000;
    localparam logic [2:0] N_RESET   = 3'b001;
    localparam logic [2:0] N_JUMP    = 3'b010;
    localparam logic [2:0] N_INCR    = 3'b011;
    localparam logic [2:0] N_CJ_INC  = 3'b100;
    localparam logic [2:0] N_CJ_DEC  = 3'b101;
    localparam logic [2:0] N_WAIT    = 3'b110;

    logic [AW-1:0] r_state;
    logic [AW-1:0] r_incr;
    logic [AW-1:0] w_next;
    logic          w_c;
    logic          w_hold;

    // Condition select and next-address mux
    always_comb begin
        w_c    = bus.cond_in[bus.select] ^ bus.inv;
        w_hold = 1'b0;
        w_next = r_state;
        case (bus.N)
            N_DECODE: w_next = bus.enc_state;
            N_RESET:  w_next = RESET_STATE;
            N_JUMP:   w_next = bus.cr;
            N_INCR:   w_next = r_incr;
            N_CJ_INC: w_next = w_c ? bus.cr : r_incr;
            N_CJ_DEC: w_next = w_c ? bus.cr : bus.enc_state;
            N_WAIT: begin
                if (w_c) begin
                    w_next = r_incr;
                end else begin
                    w_next = r_state;
                    w_hold = 1'b1;
                end
            end
            default:  w_next = RESET_STATE;
        endcase
    end

`ifdef NEXT_STATE_SEQUENCER_WATCHDOG_EN
    logic [7:0] r_wd_cnt;
    logic       r_wd_fault;
    logic       w_wd_fire;

    assign w_wd_fire = w_hold && (r_wd_cnt == WD_LIMIT);

    // Address registers with watchdog override on an over-long hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= RESET_STATE;
            r_incr     <= RESET_STATE + AW'(1);
            r_wd_cnt   <= 8'd0;
            r_wd_fault <= 1'b0;
        end else if (w_wd_fire) begin
            r_state    <= FAULT_STATE;
            r_incr     <= FAULT_STATE + AW'(1);
            r_wd_cnt   <= 8'd0;
            r_wd_fault <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_wd_cnt <= w_hold ? r_wd_cnt + 8'd1 : 8'd0;
            if (!w_hold) begin
                r_incr <= w_next + AW'(1);
            end
        end
    end

    assign bus.wd_fault = r_wd_fault;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^{FAULT_STATE, WD_LIMIT};

    // Address registers; incrementer frozen during a hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RESET_STATE;
            r_incr  <= RESET_STATE + AW'(1);
        end else begin
            r_state <= w_next;
            if (!w_hold) begin
                r_incr <= w_next + AW'(1);
            end
        end
    end

    assign bus.wd_fault = 1'b0;
`endif

    assign bus.state = r_state;
    assign bus.hold  = w_hold;

endmodule

// File: doc/next_state_sequencer.md
# next_state_sequencer

Microprogram sequencer for the control unit. It computes and registers the microstore address (`state`) for every cycle. Its inputs are the sequencing fields of the currently latched control word (`N`, `inv`, `select`, `cr`), the condition inputs, and the instruction-decode address. The microstore reads `state`, and the control register latches the resulting control word on the next clock edge.

## Interface
- `AW`, 6, microstore address width
- `RESET_STATE`, 6'd0, state loaded on reset and by N=001
- `FAULT_STATE`, 6'd63, target when the watchdog fires (macro builds only)
- `WD_LIMIT`, 8'd255, maximum consecutive hold cycles before fault (macro builds only)
- `clk`  in  1  clock; all state changes on its rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `N`  in  3  next-state mode from the control word
- `inv`  in  1  inverts the selected condition
- `select`  in  2  condition-source select
- `cr`  in  AW  jump target from the control word
- `cond_in`  in  4  condition sources: [0] memory-op-complete, [1] condition-handler result, [2] interrupt/spare, [3] constant 1
- `enc_state`  in  AW  decode address from the instruction encoder
- `state`  out  AW  registered microstore address
- `hold`  out  1  high while the current cycle is a hold (no advance)
- `wd_fault`  out  1  sticky watchdog fault flag; constant 0 when the macro is absent

## Operation
- Condition: `c = cond_in[select] ^ inv`.
- Incrementer register `incr` always holds `state+1`, modulo 2^AW (63 wraps to 0).
- Next-state mux by `N`:
  - 000: `enc_state`
  - 001: `RESET_STATE`
  - 010: `cr`
  - 011: `incr`
  - 100: `c ? cr : incr`
  - 101: `c ? cr : enc_state`
  - 110 (wait): `c ? incr : state`. When `c`=0 this is a hold cycle and `hold`=1 combinationally.
  - 111: `RESET_STATE`. This code is reserved.
- On each edge, `state <= next`. `incr <= next+1`, except in a hold cycle, where `incr` is unchanged.
- Arithmetic is unsigned, AW bits, with no carry out.

## Timing
- Reset (`reset_n`=0 at an edge):
  - `state=RESET_STATE`, `incr=RESET_STATE+1`.
  - Watchdog counter=0, `wd_fault=0`.
  - Reset overrides every `N` mode, including a hold or a pending watchdog fire.
- Latency: one edge from a control-word field change to the `state` update. The `N`/`cr` inputs observed at edge k belong to the control word latched at edge k-1. Each microinstruction therefore occupies exactly one cycle in the sequencer.
- `hold` has no registered delay. It is valid in the same cycle as `N`/`cond_in`.
- Simultaneous conditions: in mode 110, a `c` that rises in the same cycle advances the sequencer at that edge.
- Address wrap: `cr`=63 with N=011 on the following word yields `state`=0.

## Configuration
- Macro: `NEXT_STATE_SEQUENCER_WATCHDOG_EN`.
- Defined:
  - An 8-bit counter increments on each hold cycle and clears on any non-hold cycle.
  - If a hold cycle occurs while the counter equals `WD_LIMIT`, then at that edge: `state <= FAULT_STATE`, `incr <= FAULT_STATE+1`, `wd_fault <= 1` (sticky until reset), counter <= 0.
  - Counter saturation beyond `WD_LIMIT` is not reachable.
- Not defined:
  - No counter exists. `wd_fault` is tied to 0.
  - The `FAULT_STATE`/`WD_LIMIT` parameters are unused.
  - Hold cycles are unbounded.

## Test plan
- Reset and sequential advance:
  - Stimulus: hold `reset_n`=0 for 2 edges, then release with N=011 for 3 edges.
  - Required: `state` = 0, then 1, 2, 3. `wd_fault`=0 throughout.
- Conditional jump:
  - Stimulus: `state`=5, N=100, select=01, cr=6'd20.
  - With `cond_in[1]`=1, inv=0: next `state`=20.
  - With inv=1: next `state`=6.
- Decode and wait:
  - N=000 with `enc_state`=6'd12 gives `state`=12.
  - Then N=110, select=00, `cond_in[0]`=0 for 3 edges: `state` stays 12 and `hold`=1.
  - Then `cond_in[0]`=1: `state`=13.
- Wrap-around and reserved code:
  - N=010 with cr=63, then N=011: `state`=63, then 0.
  - N=111 from any state: `state`=0.
- Watchdog (macro defined, `WD_LIMIT`=4):
  - Stimulus: N=110 with `c`=0 held.
  - Required: `state` held for 4 edges. At the 5th edge, `state`=63 and `wd_fault`=1.
  - `wd_fault` stays 1 until `reset_n`=0, which clears it and sets `state`=0.
  - Without the macro, the same stimulus holds forever with `wd_fault`=0.
- Reset mid-hold:
  - Stimulus: assert `reset_n`=0 during a 110 hold.
  - Required: `state`=0 and counter=0 at that edge.
  - Required: resuming the hold restarts the full `WD_LIMIT` count.
